// File: rtl/rtmc_reg_arb_if.sv
// Requester ports and shared register bus seen by rtmc_reg_arb.
// master = arbiter side, slave = requesters plus register target.
interface rtmc_reg_arb_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdat;
   logic              m0_wr;
   logic              m0_rd;
   logic [DATA_W-1:0] m0_rdat;
   logic              m0_ack;
   logic              m0_err;

   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdat;
   logic              m1_wr;
   logic              m1_rd;
   logic [DATA_W-1:0] m1_rdat;
   logic              m1_ack;
   logic              m1_err;

   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdat;
   logic              reg_wr;
   logic              reg_rd;
   logic [DATA_W-1:0] reg_rdat;
   logic              reg_ack;

   logic              gnt;
   logic              busy;

   modport master (
      input  m0_addr, m0_wdat, m0_wr, m0_rd,
      output m0_rdat, m0_ack, m0_err,
      input  m1_addr, m1_wdat, m1_wr, m1_rd,
      output m1_rdat, m1_ack, m1_err,
      output reg_addr, reg_wdat, reg_wr, reg_rd,
      input  reg_rdat, reg_ack,
      output gnt, busy
   );

   modport slave (
      output m0_addr, m0_wdat, m0_wr, m0_rd,
      input  m0_rdat, m0_ack, m0_err,
      output m1_addr, m1_wdat, m1_wr, m1_rd,
      input  m1_rdat, m1_ack, m1_err,
      input  reg_addr, reg_wdat, reg_wr, reg_rd,
      output reg_rdat, reg_ack,
      input  gnt, busy
   );
endinterface

// File: rtl/rtmc_reg_arb.sv
// Two-requester round-robin register-bus arbiter; strobe 1 cycle after grant, mN_ack 1 cycle after reg_ack or timeout.
// A losing requester simply stays pending; a DONE dead cycle separates transactions (min turnaround 3 cycles).
module rtmc_reg_arb #(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   rtmc_reg_arb_if.master bus
);
   localparam int               CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
   localparam bit               TO_EN  = (TIMEOUT != 0);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              ptr;
   logic              owner;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdat_q;
   logic              wr_q;
   logic              rd_q;
   logic [DATA_W-1:0] rdat0_q;
   logic [DATA_W-1:0] rdat1_q;
   logic              ack0_q;
   logic              ack1_q;
   logic              err0_q;
   logic              err1_q;
   logic              busy_q;

   logic              req0;
   logic              req1;
   logic              win;
   logic              expire;
   logic              finish;
   logic [DATA_W-1:0] rsp_dat;

   assign req0 = bus.m0_wr | bus.m0_rd;
   assign req1 = bus.m1_wr | bus.m1_rd;

   // On a tie the requester that did not win last time gets the bus.
   always_comb begin
      win = 1'b0;
      if (req0 && req1) win = ~ptr;
      else if (req1)    win = 1'b1;
   end

   assign expire  = TO_EN && (cnt == TO_LIM);
   assign finish  = bus.reg_ack | expire;
   assign rsp_dat = bus.reg_ack ? bus.reg_rdat : '1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         ptr     <= 1'b1;
         owner   <= 1'b0;
         addr_q  <= '0;
         wdat_q  <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         rdat0_q <= '0;
         rdat1_q <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         err0_q <= 1'b0;
         err1_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner  <= win;
                  ptr    <= win;
                  cnt    <= '0;
                  addr_q <= win ? bus.m1_addr : bus.m0_addr;
                  wdat_q <= win ? bus.m1_wdat : bus.m0_wdat;
                  wr_q   <= win ? bus.m1_wr : bus.m0_wr;
                  // Write takes precedence when both strobes are up.
                  rd_q   <= win ? (bus.m1_rd & ~bus.m1_wr) : (bus.m0_rd & ~bus.m0_wr);
                  busy_q <= 1'b1;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (finish) begin
                  wr_q <= 1'b0;
                  rd_q <= 1'b0;
                  if (rd_q) begin
                     if (owner) rdat1_q <= rsp_dat;
                     else       rdat0_q <= rsp_dat;
                  end
                  if (owner) begin
                     ack1_q <= 1'b1;
                     err1_q <= ~bus.reg_ack;
                  end else begin
                     ack0_q <= 1'b1;
                     err0_q <= ~bus.reg_ack;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.reg_addr = addr_q;
   assign bus.reg_wdat = wdat_q;
   assign bus.reg_wr   = wr_q;
   assign bus.reg_rd   = rd_q;
   assign bus.m0_rdat  = rdat0_q;
   assign bus.m0_ack   = ack0_q;
   assign bus.m0_err   = err0_q;
   assign bus.m1_rdat  = rdat1_q;
   assign bus.m1_ack   = ack1_q;
   assign bus.m1_err   = err1_q;
   assign bus.gnt      = owner;
   assign bus.busy     = busy_q;
endmodule

// File: doc/rtmc_reg_arb.md
Name: rtmc_reg_arb

Overview:
- Two-requester arbiter that shares the single register bus between the SPI slave (requester 0) and an internal on-chip master such as a future motion sequencer (requester 1).
- Sits in the core between the requesters and the register file / peripheral decode.
- Serialises accesses with round-robin fairness and forwards one transaction at a time.
- Guarantees completion via an ack timeout, so a missing target can never hang SPI.

Parameters:
ADDR_W, 7, register address width
DATA_W, 8, register data width
TIMEOUT, 15, max cycles waiting for reg_ack before forced completion; 0 disables timeout

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
m0_addr  input  ADDR_W  requester 0 address
m0_wdat  input  DATA_W  requester 0 write data
m0_wr  input  1  requester 0 write request (level)
m0_rd  input  1  requester 0 read request (level)
m0_rdat  output  DATA_W  requester 0 read data
m0_ack  output  1  requester 0 completion pulse
m0_err  output  1  requester 0 timeout flag, pulses with m0_ack
m1_addr, m1_wdat, m1_wr, m1_rd, m1_rdat, m1_ack, m1_err: same as m0_*, for requester 1
reg_addr  output  ADDR_W  register bus address
reg_wdat  output  DATA_W  register bus write data
reg_wr  output  1  register bus write strobe (level until ack)
reg_rd  output  1  register bus read strobe (level until ack)
reg_rdat  input  DATA_W  register bus read data, valid with reg_ack
reg_ack  input  1  target completion, one-cycle pulse
gnt  output  1  index of current or last owner
busy  output  1  high in BUSY and DONE states

Behaviour:
- Single clock domain, clk. rst_n is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - State IDLE; timeout counter 0.
  - Round-robin pointer = 1, so requester 0 wins the first tie.
- Request rule:
  - reqN = mN_wr | mN_rd.
  - Requester holds addr, wdat and the strobe stable until it sees mN_ack, then drops the strobe.
  - If both mN_wr and mN_rd are high, the transaction is a write; rd is ignored.
- State IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester not equal to the pointer.
  - On grant: capture addr/wdat/op into output registers, set gnt, update pointer to the winner, clear the counter, go to BUSY.
- State BUSY:
  - reg_wr or reg_rd held high, reg_addr and reg_wdat stable.
  - Counter increments each cycle.
  - On reg_ack=1:
    - Capture reg_rdat into the owner's mN_rdat (reads only; writes leave mN_rdat unchanged).
    - Drop the strobes; pulse mN_ack for 1 cycle; go to DONE.
  - If TIMEOUT≠0, counter==TIMEOUT and no ack:
    - Same completion path, but mN_rdat = all-ones for reads.
    - mN_err pulses together with mN_ack.
- State DONE: one dead cycle so the requester can drop its strobe; return to IDLE unconditionally.
- Latency, request sampled in IDLE at cycle N:
  - Bus strobe at N+1.
  - Ack at cycle M ≥ N+1 gives mN_ack at M+1.
  - Next arbitration at M+2.
  - Minimum turnaround is 3 cycles.
- reg_ack in IDLE or DONE: ignored.
- mN_rdat holds its value until the next read completion for that requester.
- Requester drops its request while BUSY (protocol violation): the transaction still completes and the ack is still issued.
- Loser's request stays pending with no side effects.
- Both requesters continuously requesting: grants alternate 0,1,0,1.
- rst_n asserted mid-transaction: immediate return to reset values; no ack issued.

Test Plan:
- m0 write addr 0x05, data 0xA5; target acks 2 cycles after strobe -> reg_wr high for 3 cycles with reg_addr=0x05, reg_wdat=0xA5; m0_ack single pulse; m1_ack stays 0.
- m1 read addr 0x12; target returns 0x3C with ack -> m1_rdat=0x3C at the m1_ack cycle and held afterwards; gnt=1; m0_rdat unchanged.
- m0 and m1 both assert reads in the same cycle after reset, held for 4 transactions -> grant order 0,1,0,1; each ack goes only to its owner.
- Read with no target ack, TIMEOUT=15 -> m0_ack and m0_err pulse exactly 16 cycles after reg_rd rises; m0_rdat=0xFF; state returns to IDLE.
- m0_wr and m0_rd both high -> reg_wr=1, reg_rd=0.
- rst_n pulsed low while BUSY -> reg_wr/reg_rd/busy drop asynchronously, no ack pulse; after release, the first tie goes to m0.
